lane_encoder: RTL and testbench
===============================

LANE_ENCODER -- requirements
Module: lane_encoder

Interface
REQ-001 Parameter DB_CYCLES, default 4, is the number of consecutive cycles a synchronized key level must differ from the debounced level before it is accepted; the legal range is 2..65535.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port key_in, input, 4 bits: raw, asynchronous, active-high lane buttons; bit i is lane i.
REQ-005 Port ack, input, 1 bit: the consumer accepts the current code when ack=1 while valid=1.
REQ-006 Port code, output, 2 bits: the binary lane index of the presented press event.
REQ-007 Port valid, output, 1 bit: code holds an unconsumed press event.
REQ-008 Port overflow, output, 1 bit: one-cycle pulse that flags a dropped (merged) press.

Function
REQ-009 Each key_in bit SHALL pass through a two-flop synchronizer; the second stage is called s2[i].
REQ-010 Each lane SHALL keep a debounced level stable[i] and a 16-bit counter cnt[i].
REQ-011 Per-edge update for each lane:
- If s2[i]==stable[i]: cnt[i] SHALL be set to 0.
- Else if cnt[i]==DB_CYCLES-1: stable[i] SHALL be set to s2[i] and cnt[i] to 0.
- Otherwise cnt[i] SHALL increment by 1.
REQ-012 A press event on lane i SHALL occur on the edge where stable[i] goes 0->1; release (1->0) SHALL generate no event.
REQ-013 A press event SHALL set pending[i] on the same edge.
REQ-014 The output stage SHALL be a two-state FSM, IDLE (valid=0) and HOLD (valid=1).
REQ-015 In IDLE with pending!=0, the FSM SHALL load code with the lowest pending index, clear that pending bit, and enter HOLD on the same edge.
REQ-016 In HOLD with ack=0, code and valid SHALL hold unchanged.
REQ-017 In HOLD with ack=1:
- If pending!=0, the FSM SHALL load the next lowest pending index, clear that bit, and stay in HOLD (back-to-back, no bubble).
- Otherwise it SHALL go to IDLE.
REQ-018 ack while valid=0 SHALL be ignored.
REQ-019 If a press event on lane i coincides with pending[i] being cleared by a load, pending[i] SHALL remain 1.
REQ-020 If a press event on lane i occurs while pending[i]=1 and pending[i] is not being cleared, the event SHALL be merged and overflow SHALL pulse high for exactly that one cycle.
REQ-021 Presses on several lanes that debounce on the same edge SHALL all set pending and then be emitted in ascending lane order.
REQ-022 Latency SHALL be exactly DB_CYCLES+3 rising edges from the first edge that samples key_in[i]=1 to valid=1, given a steady key, FSM in IDLE, and pending=0.
REQ-023 A glitch shorter than DB_CYCLES synchronized cycles SHALL leave stable and pending unchanged.

Reset
REQ-024 While rst=1, the following SHALL be 0 asynchronously:
- synchronizer flops, stable, cnt, pending
- FSM state (IDLE)
- code=2'b00, valid=0, overflow=0
REQ-025 A reset asserted mid-debounce or in HOLD SHALL discard all in-flight and pending events.
REQ-026 After rst deasserts, a key already held high SHALL be treated as a new press and produce one event after the REQ-022 latency.

Verification (DB_CYCLES=4)
REQ-027 Scenario 1: key_in=4'b0100 steady from edge 1, ack=0 -> valid=1 and code=2'b10 at edge 7, and both hold while ack=0.
REQ-028 Scenario 2: key_in[1] high for 3 cycles, then low -> valid stays 0, pending stays 0.
REQ-029 Scenario 3: key_in=4'b1011 rising together, ack held 1 -> code sequence 00, 01, 11 on three consecutive valid cycles, then valid=0.
REQ-030 Scenario 4: lane 0 pressed, released, and re-pressed (both presses debounced) while its first event sits unacked in HOLD behind a pending lane-0 event -> one overflow pulse, with exactly two lane-0 events delivered after acks.
REQ-031 Scenario 5: rst pulsed while valid=1 with pending=4'b1000 -> valid=0, code=00, pending=0 immediately; no event follows after release if all keys are low.
REQ-032 Scenario 6: a lane-2 debounce completes on the same edge that pending[2] is loaded -> pending[2] stays 1 and a second code=10 is delivered after the next ack.

Source files
------------

// File: rtl/lane_encoder.sv
// Four debounced lanes feed a pending set. The lowest pending lane is presented as code/valid; key to valid takes DB_CYCLES+3 edges.
// code/valid hold until ack, an acked slot reloads back-to-back, and overflow pulses when a press merges into one already pending.
module lane_encoder #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  input  logic       ack,
  output logic [1:0] code,
  output logic       valid,
  output logic       overflow
);

  localparam logic [15:0] DbLast = 16'(DB_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stateT;

  logic [3:0]  syncA;
  logic [3:0]  syncB;
  logic [3:0]  stable;
  logic [3:0]  stableNext;
  logic [15:0] cnt [4];
  logic [15:0] cntNext [4];
  logic [3:0]  pressNow;
  logic [3:0]  pending;
  logic [3:0]  pendingNext;
  logic [3:0]  clearMask;
  logic [1:0]  lowIdx;
  logic [1:0]  codeNext;
  logic        loadEn;
  logic        overflowNext;
  stateT       state;
  stateT       stateNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= key_in;
      syncB <= syncA;
    end
  end

  // A lane flips only after its synchronized level has disagreed for DB_CYCLES edges in a row.
  always_comb begin
    stableNext = stable;
    pressNow   = '0;
    for (int i = 0; i < 4; i++) begin
      cntNext[i] = cnt[i] + 16'd1;
      if (syncB[i] == stable[i]) begin
        cntNext[i] = '0;
      end else if (cnt[i] == DbLast) begin
        cntNext[i]    = '0;
        stableNext[i] = syncB[i];
        pressNow[i]   = syncB[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable <= stableNext;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cntNext[i];
      end
    end
  end

  always_comb begin
    lowIdx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        lowIdx = 2'(i);
      end
    end
  end

  always_comb begin
    stateNext = state;
    codeNext  = code;
    loadEn    = 1'b0;
    case (state)
      IDLE: begin
        if (pending != 4'd0) begin
          loadEn    = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          if (pending != 4'd0) begin
            loadEn = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (loadEn) begin
      codeNext = lowIdx;
    end
  end

  // A press landing on the bit being loaded re-arms it instead of being lost or counted as a merge.
  assign clearMask    = loadEn ? (4'b0001 << lowIdx) : 4'b0000;
  assign pendingNext  = (pending & ~clearMask) | pressNow;
  assign overflowNext = |(pressNow & pending & ~clearMask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      code     <= 2'b00;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      pending  <= pendingNext;
      code     <= codeNext;
      overflow <= overflowNext;
    end
  end

  assign valid = (state == HOLD);

endmodule

// File: tb/tb_lane_encoder.sv
// Randomized and directed bench for lane_encoder with a set-based reference model and a code scoreboard.
module tb_lane_encoder;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] key_in;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic       overflow;

  int nErr;
  int nChecks;
  int expQ[$];

  bit [3:0] mS1, mS2, mLevel, mPend, mPress, mClr, mNextLevel;
  int       mRun [4];
  bit       mValid, mOvf;
  int       mIdx;

  lane_encoder #(.DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .ack      (ack),
    .code     (code),
    .valid    (valid),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each lane holds a level and a run length of disagreeing samples; a press
  // enters a pending set, and one output slot takes the smallest member whenever it is free or acked.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mS1 = 0; mS2 = 0; mLevel = 0; mPend = 0; mValid = 0; mOvf = 0;
        for (int i = 0; i < 4; i++) mRun[i] = 0;
        expQ.delete();
      end else begin
        mPress = 0;
        mNextLevel = mLevel;
        for (int i = 0; i < 4; i++) begin
          if (mS2[i] != mLevel[i]) begin
            if (mRun[i] == DB - 1) begin
              mNextLevel[i] = mS2[i];
              mRun[i] = 0;
              mPress[i] = mS2[i];
            end else begin
              mRun[i] = mRun[i] + 1;
            end
          end else begin
            mRun[i] = 0;
          end
        end
        mClr = 0;
        if (mPend != 0 && (!mValid || ack)) begin
          mIdx = 0;
          for (int i = 3; i >= 0; i--) if (mPend[i]) mIdx = i;
          mClr[mIdx] = 1'b1;
          expQ.push_back(mIdx);
          mValid = 1'b1;
        end else if (mValid && ack) begin
          mValid = 1'b0;
        end
        mOvf   = |(mPress & mPend & ~mClr);
        mPend  = (mPend & ~mClr) | mPress;
        mLevel = mNextLevel;
        mS2    = mS1;
        mS1    = key_in;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_hold_valid", int'(valid), 0);
        chk("rst_hold_code", int'(code), 0);
        chk("rst_hold_overflow", int'(overflow), 0);
      end else begin
        chk("valid", int'(valid), int'(mValid));
        chk("overflow", int'(overflow), int'(mOvf));
        if (valid) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nErr++;
            $display("FAIL code_unexpected: got %0d expected no event", code);
          end else begin
            chk("code", int'(code), expQ[0]);
            if (ack) void'(expQ.pop_front());
          end
        end
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    key_in = 4'b0000;
    ack = 1'b0;
    #1;
    chk("reset_valid", int'(valid), 0);
    chk("reset_code", int'(code), 0);
    chk("reset_overflow", int'(overflow), 0);
    repeat (3) tick();
    rst = 1'b0;
  endtask

  int cntV;
  int ovfCnt;
  int deliv;
  int firstE;
  int lastE;
  int codes[$];
  int expC[3];
  int lane;

  initial begin
    nErr = 0;
    nChecks = 0;
    rst = 1'b1;
    key_in = 4'b0000;
    ack = 1'b0;

    // Single lane 2 press: valid exactly at edge 7, then held while ack stays low.
    doReset();
    key_in = 4'b0100;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) chk("s1_valid_edge6", int'(valid), 0);
      if (e >= 7) begin
        chk("s1_valid_hold", int'(valid), 1);
        chk("s1_code_hold", int'(code), 2);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("s1_after_ack", int'(valid), 0);
    key_in = 4'b0000;
    repeat (10) tick();

    // Three-cycle glitch on lane 1 must not produce an event.
    doReset();
    key_in = 4'b0010;
    repeat (3) tick();
    key_in = 4'b0000;
    cntV = 0;
    repeat (15) begin
      tick();
      if (valid) cntV++;
    end
    chk("s2_glitch_no_valid", cntV, 0);

    // Simultaneous presses on lanes 0,1,3 with ack held high.
    doReset();
    ack = 1'b1;
    key_in = 4'b1011;
    codes.delete();
    firstE = -1;
    lastE = -1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (valid) begin
        codes.push_back(int'(code));
        if (firstE < 0) firstE = e;
        lastE = e;
      end
    end
    expC = '{0, 1, 3};
    chk("s3_count", codes.size(), 3);
    for (int k = 0; k < 3; k++) chk("s3_code_order", (k < codes.size()) ? codes[k] : -1, expC[k]);
    chk("s3_first_edge", firstE, 7);
    chk("s3_last_edge", lastE, 9);
    ack = 1'b0;
    key_in = 4'b0000;
    repeat (10) tick();

    // Lane 0 pressed three times with no ack: one merge, two deliveries.
    doReset();
    ovfCnt = 0;
    for (int p = 0; p < 6; p++) begin
      key_in = (p % 2 == 0) ? 4'b0001 : 4'b0000;
      repeat (10) begin
        tick();
        if (overflow) ovfCnt++;
      end
    end
    chk("s4_overflow_pulses", ovfCnt, 1);
    chk("s4_valid_before_ack", int'(valid), 1);
    ack = 1'b1;
    deliv = 0;
    repeat (10) begin
      if (valid) begin
        deliv++;
        chk("s4_code", int'(code), 0);
      end
      tick();
    end
    chk("s4_deliveries", deliv, 2);
    ack = 1'b0;

    // Reset while lane 1 is held and lane 3 pending.
    doReset();
    key_in = 4'b1010;
    repeat (8) tick();
    chk("s5_pre_valid", int'(valid), 1);
    chk("s5_pre_code", int'(code), 1);
    doReset();
    ack = 1'b1;
    cntV = 0;
    repeat (15) begin
      tick();
      if (valid) cntV++;
    end
    chk("s5_no_event_after_reset", cntV, 0);
    ack = 1'b0;

    // Lane 2 re-press completes on the very edge its pending bit is loaded.
    doReset();
    ovfCnt = 0;
    for (int e = 1; e <= 24; e++) begin
      key_in = {1'b0, (e < 8 || e >= 14), 1'b0, 1'b1};
      ack = (e >= 19 && e <= 21);
      tick();
      if (overflow) ovfCnt++;
      if (e == 18) begin
        chk("s6_valid_e18", int'(valid), 1);
        chk("s6_code_e18", int'(code), 0);
      end
      if (e == 19 || e == 20) begin
        chk("s6_valid_reload", int'(valid), 1);
        chk("s6_code_reload", int'(code), 2);
      end
      if (e == 21) chk("s6_idle_e21", int'(valid), 0);
    end
    chk("s6_no_overflow", ovfCnt, 0);
    ack = 1'b0;
    key_in = 4'b0000;
    repeat (10) tick();

    // Random keys, acks and occasional resets, checked by the model and scoreboard.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        lane = $urandom_range(0, 3);
        key_in[lane] = ~key_in[lane];
      end
      ack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    key_in = 4'b0000;
    ack = 1'b1;
    repeat (40) tick();
    chk("drain_queue_empty", expQ.size(), 0);
    chk("drain_idle", int'(valid), 0);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
